seg_display: RTL and testbench

//   Free-running 32-bit hexadecimal counter shown on eight 7-segment digits.

---
 rtl/seg_display.sv | 88 ++++++++
 tb/tb_seg_display.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seg_display.sv
// seg_display: free-running 32-bit hex counter decoded onto eight active-low 7-segment digits.
//   Parameters: CLK_DIV (clocks per count step, 1..2^32-1), STEP (added to count per step, mod 2^32).
//   Ports: clk            - system clock, all state on rising edge
//          rst            - asynchronous active-low reset
//          o_seg0..o_seg7 - registered segment patterns, digit 0 = count[3:0] ... digit 7 = count[31:28],
//                           bit map [0]=a..[6]=g [7]=dp, 0 = lit, dp always off
//   Optional macro SEG_LEAD_ZERO_BLANK_EN: blank (8'hFF) digits above the most-significant non-zero
//   nibble; digit 0 is never blanked.
module seg_display #(
    parameter logic [31:0] CLK_DIV = 32'd5_000_000,
    parameter logic [31:0] STEP    = 32'd1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] o_seg0,
    output logic [7:0] o_seg1,
    output logic [7:0] o_seg2,
    output logic [7:0] o_seg3,
    output logic [7:0] o_seg4,
    output logic [7:0] o_seg5,
    output logic [7:0] o_seg6,
    output logic [7:0] o_seg7
);
    logic [31:0] r_presc;
    logic [31:0] r_count;
    logic [7:0]  r_seg [8];
    logic [7:0]  w_seg [8];

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hC0;
            4'h1: hex7 = 8'hF9;
            4'h2: hex7 = 8'hA4;
            4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;
            4'h5: hex7 = 8'h92;
            4'h6: hex7 = 8'h82;
            4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;
            4'h9: hex7 = 8'h90;
            4'hA: hex7 = 8'h88;
            4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;
            4'hD: hex7 = 8'hA1;
            4'hE: hex7 = 8'h86;
            default: hex7 = 8'h8E;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_count <= '0;
        end else if (r_presc == CLK_DIV - 32'd1) begin
            r_presc <= '0;
            r_count <= r_count + STEP;
        end else begin
            r_presc <= r_presc + 32'd1;
        end
    end

    for (genvar d = 0; d < 8; d++) begin : g_dig
`ifdef SEG_LEAD_ZERO_BLANK_EN
        // A digit is a leading zero when it and every nibble above it are zero.
        localparam logic [7:0] RST_VAL = (d == 0) ? 8'hC0 : 8'hFF;
        assign w_seg[d] = (d != 0 && r_count[31:4*d] == '0) ? 8'hFF : hex7(r_count[4*d+:4]);
`else
        localparam logic [7:0] RST_VAL = 8'hC0;
        assign w_seg[d] = hex7(r_count[4*d+:4]);
`endif
        // Registering the decode keeps the pins glitch-free; all digits share one edge.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                r_seg[d] <= RST_VAL;
            else
                r_seg[d] <= w_seg[d];
        end
    end

    assign o_seg0 = r_seg[0];
    assign o_seg1 = r_seg[1];
    assign o_seg2 = r_seg[2];
    assign o_seg3 = r_seg[3];
    assign o_seg4 = r_seg[4];
    assign o_seg5 = r_seg[5];
    assign o_seg6 = r_seg[6];
    assign o_seg7 = r_seg[7];
endmodule

// File: tb/tb_seg_display.sv
// tb_seg_display: directed self-checking bench for seg_display across several CLK_DIV/STEP builds.
module tb_seg_display;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;

`ifdef SEG_LEAD_ZERO_BLANK_EN
    localparam logic [7:0] BLK = 8'hFF;
`else
    localparam logic [7:0] BLK = 8'hC0;
`endif

    logic [7:0] s4 [8];
    logic [7:0] s1 [8];
    logic [7:0] sf [8];
    logic [7:0] sh [8];
    logic [7:0] s16 [8];

    always #5 clk = ~clk;

    seg_display #(.CLK_DIV(32'd4), .STEP(32'd1)) u4 (.clk(clk), .rst(rst),
        .o_seg0(s4[0]), .o_seg1(s4[1]), .o_seg2(s4[2]), .o_seg3(s4[3]),
        .o_seg4(s4[4]), .o_seg5(s4[5]), .o_seg6(s4[6]), .o_seg7(s4[7]));
    seg_display #(.CLK_DIV(32'd1), .STEP(32'd1)) u1 (.clk(clk), .rst(rst),
        .o_seg0(s1[0]), .o_seg1(s1[1]), .o_seg2(s1[2]), .o_seg3(s1[3]),
        .o_seg4(s1[4]), .o_seg5(s1[5]), .o_seg6(s1[6]), .o_seg7(s1[7]));
    seg_display #(.CLK_DIV(32'd1), .STEP(32'hFFFF_FFFF)) uf (.clk(clk), .rst(rst),
        .o_seg0(sf[0]), .o_seg1(sf[1]), .o_seg2(sf[2]), .o_seg3(sf[3]),
        .o_seg4(sf[4]), .o_seg5(sf[5]), .o_seg6(sf[6]), .o_seg7(sf[7]));
    seg_display #(.CLK_DIV(32'd1), .STEP(32'h8000_0000)) uh (.clk(clk), .rst(rst),
        .o_seg0(sh[0]), .o_seg1(sh[1]), .o_seg2(sh[2]), .o_seg3(sh[3]),
        .o_seg4(sh[4]), .o_seg5(sh[5]), .o_seg6(sh[6]), .o_seg7(sh[7]));
    seg_display #(.CLK_DIV(32'd2), .STEP(32'd16)) u16 (.clk(clk), .rst(rst),
        .o_seg0(s16[0]), .o_seg1(s16[1]), .o_seg2(s16[2]), .o_seg3(s16[3]),
        .o_seg4(s16[4]), .o_seg5(s16[5]), .o_seg6(s16[6]), .o_seg7(s16[7]));

    function automatic logic [7:0] rv(input int i);
        return (i == 0) ? 8'hC0 : BLK;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (s4[i] !== rv(i)) begin
                fails++;
                $display("FAIL reset_async seg%0d got %h exp %h", i, s4[i], rv(i));
            end
        end
        for (int c = 0; c < 3; c++) begin
            tick(1);
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (s4[i] !== rv(i)) begin
                    fails++;
                    $display("FAIL reset_hold clk%0d seg%0d got %h exp %h", c, i, s4[i], rv(i));
                end
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_count();
        reset_pulse();
        tick(4);
        tests++;
        if (s4[0] !== 8'hC0) begin fails++; $display("FAIL count_edge4 seg0 got %h exp c0", s4[0]); end
        tick(1);
        tests++;
        if (s4[0] !== 8'hF9) begin fails++; $display("FAIL count_edge5 seg0 got %h exp f9", s4[0]); end
        for (int i = 1; i < 8; i++) begin
            tests++;
            if (s4[i] !== BLK) begin fails++; $display("FAIL count_edge5 seg%0d got %h exp %h", i, s4[i], BLK); end
        end
        tick(35);
        tests++;
        if (s4[0] !== 8'h90) begin fails++; $display("FAIL count_edge40 seg0 got %h exp 90", s4[0]); end
        tick(1);
        tests++;
        if (s4[0] !== 8'h88) begin fails++; $display("FAIL count_edge41 seg0 got %h exp 88", s4[0]); end
    endtask

    task automatic test_nibble_carry();
        reset_pulse();
        tick(16);
        tests++;
        if (s1[0] !== 8'h8E) begin fails++; $display("FAIL carry_f seg0 got %h exp 8e", s1[0]); end
        tests++;
        if (s1[1] !== BLK) begin fails++; $display("FAIL carry_f seg1 got %h exp %h", s1[1], BLK); end
        tick(1);
        tests++;
        if (s1[0] !== 8'hC0) begin fails++; $display("FAIL carry_10 seg0 got %h exp c0", s1[0]); end
        tests++;
        if (s1[1] !== 8'hF9) begin fails++; $display("FAIL carry_10 seg1 got %h exp f9", s1[1]); end
        tests++;
        if (s1[2] !== BLK) begin fails++; $display("FAIL carry_10 seg2 got %h exp %h", s1[2], BLK); end
    endtask

    task automatic test_wrap();
        reset_pulse();
        tick(2);
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (sf[i] !== 8'h8E) begin fails++; $display("FAIL wrap_ffffffff seg%0d got %h exp 8e", i, sf[i]); end
            tests++;
            if (sh[i] !== ((i == 7) ? 8'h80 : 8'hC0)) begin
                fails++;
                $display("FAIL wrap_80000000 seg%0d got %h exp %h", i, sh[i], (i == 7) ? 8'h80 : 8'hC0);
            end
        end
        tick(1);
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (sh[i] !== rv(i)) begin fails++; $display("FAIL wrap_zero seg%0d got %h exp %h", i, sh[i], rv(i)); end
            tests++;
            if (sf[i] !== ((i == 0) ? 8'h86 : 8'h8E)) begin
                fails++;
                $display("FAIL wrap_fffffffe seg%0d got %h exp %h", i, sf[i], (i == 0) ? 8'h86 : 8'h8E);
            end
        end
    endtask

    task automatic test_async_reset();
        reset_pulse();
        tick(6);
        tests++;
        if (s4[0] !== 8'hF9) begin fails++; $display("FAIL async_pre seg0 got %h exp f9", s4[0]); end
        #3 rst = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (s4[i] !== rv(i)) begin fails++; $display("FAIL async_now seg%0d got %h exp %h", i, s4[i], rv(i)); end
        end
        tick(1);
        rst = 1'b1;
        tick(4);
        tests++;
        if (s4[0] !== 8'hC0) begin fails++; $display("FAIL async_edge4 seg0 got %h exp c0", s4[0]); end
        tick(1);
        tests++;
        if (s4[0] !== 8'hF9) begin fails++; $display("FAIL async_edge5 seg0 got %h exp f9", s4[0]); end
    endtask

    task automatic test_step16();
        reset_pulse();
        tick(4);
        tests++;
        if (s16[1] !== 8'hF9) begin fails++; $display("FAIL step16_one seg1 got %h exp f9", s16[1]); end
        tick(1);
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (s16[i] !== ((i == 1) ? 8'hA4 : rv(i))) begin
                fails++;
                $display("FAIL step16_two seg%0d got %h exp %h", i, s16[i], (i == 1) ? 8'hA4 : rv(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_nibble_carry();
        test_wrap();
        test_async_reset();
        test_step16();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
